// File: rtl/riscv_fetch_if.sv
// Fetch-stage bus: instruction memory port, redirect request and the
// fetch->decode handshake, plus a debug view of the buffer state.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef IMEM_ADDR_BIT
`define IMEM_ADDR_BIT 12
`endif

// Handshake: decode takes the head on any cycle where o_if_valid and
// i_id_ready are both high and i_redirect is low; the head holds steady
// while o_if_valid is high and i_id_ready is low.
interface riscv_fetch_if;
  logic [`IMEM_ADDR_BIT-3:0] o_imem_addr;
  logic [`XLEN-1:0]          i_imem_data;
  logic                      i_redirect;
  logic [`XLEN-1:0]          i_redirect_pc;
  logic                      o_if_valid;
  logic [`XLEN-1:0]          o_if_instr;
  logic [`XLEN-1:0]          o_if_pc;
  logic                      i_id_ready;
  logic [1:0]                dbg_state;

  // Fetch stage side
  modport master (
    output o_imem_addr,
    input  i_imem_data,
    input  i_redirect,
    input  i_redirect_pc,
    output o_if_valid,
    output o_if_instr,
    output o_if_pc,
    input  i_id_ready,
    output dbg_state
  );

  // Memory / decode / back-end side
  modport slave (
    input  o_imem_addr,
    output i_imem_data,
    output i_redirect,
    output i_redirect_pc,
    input  o_if_valid,
    input  o_if_instr,
    input  o_if_pc,
    output i_id_ready,
    input  dbg_state
  );
endinterface

// File: rtl/riscv_fetch.sv
// RISC-V instruction fetch: PC register, combinational imem address,
// 2-entry {pc, instr} fetch buffer and redirect flush.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef IMEM_ADDR_BIT
`define IMEM_ADDR_BIT 12
`endif

module riscv_fetch #(
  parameter logic [`XLEN-1:0] RESET_PC = '0
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  riscv_fetch_if.master bus
);

  // Buffer occupancy doubles as the FSM state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic [`XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[`XLEN-1:2], 2'b00};

  state_e                 state_q, state_d;
  logic [`XLEN-1:0]       pc_q, pc_d;
  logic [1:0][`XLEN-1:0]  buf_pc_q, buf_pc_d;
  logic [1:0][`XLEN-1:0]  buf_instr_q, buf_instr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic                   pop;
  logic                   push;
  logic                   tail;
  logic                   unused_redirect_lsbs;

  // Target low bits are forced to zero, so they never reach the PC.
  assign unused_redirect_lsbs = ^bus.i_redirect_pc[1:0];

  // Handshake decode, buffer write, pointer and occupancy next-state.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    rd_ptr_d    = rd_ptr_q;

    // A redirect kills both the head handoff and the in-flight fetch.
    pop  = (state_q != EMPTY) & bus.i_id_ready & ~bus.i_redirect;
    push = ~bus.i_redirect & ((state_q != FULL) | pop);
    // Tail is read pointer + occupancy (mod 2); when FULL it is the head
    // slot, which a same-cycle pop is vacating.
    tail = rd_ptr_q ^ (state_q == ONE);

    if (bus.i_redirect) begin
      state_d = EMPTY;
      pc_d    = {bus.i_redirect_pc[`XLEN-1:2], 2'b00};
    end else begin
      if (push) begin
        buf_pc_d[tail]    = pc_q;
        buf_instr_d[tail] = bus.i_imem_data;
        pc_d              = pc_q + `XLEN'(4);
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case (state_q)
        EMPTY:   if (push) state_d = ONE;
        ONE: begin
          if (push & ~pop)      state_d = FULL;
          else if (pop & ~push) state_d = EMPTY;
        end
        FULL:    if (pop & ~push) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= EMPTY;
      pc_q        <= RESET_PC_ALIGNED;
      buf_pc_q    <= '0;
      buf_instr_q <= '0;
      rd_ptr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  assign bus.o_imem_addr = pc_q[`IMEM_ADDR_BIT-1:2];
  assign bus.o_if_valid  = (state_q != EMPTY);
  assign bus.o_if_pc     = buf_pc_q[rd_ptr_q];
  assign bus.o_if_instr  = buf_instr_q[rd_ptr_q];
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_riscv_fetch.sv
// Directed bench for riscv_fetch: queue-level reference model checked every
// cycle, plus hand-computed literal expectations along the test plan.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef IMEM_ADDR_BIT
`define IMEM_ADDR_BIT 12
`endif

module tb_riscv_fetch;
  localparam int AW = `IMEM_ADDR_BIT;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  riscv_fetch_if bus ();

  riscv_fetch #(.RESET_PC(RST_PC)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  // Memory image: mem[k] = 0x1000 + k
  assign bus.i_imem_data = 32'h1000 + 32'(bus.o_imem_addr);

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    logic [AW-3:0] widx;
    widx = pc[AW-1:2];
    return 32'h1000 + 32'(widx);
  endfunction

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The buffer is an ordered queue of at most two {pc, instr} entries.
  logic [31:0] exp_q[$];       // expected pcs, head first
  logic [31:0] exp_instr_q[$]; // matching instruction words
  logic [31:0] mpc = RST_PC;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exp_q.delete();
      exp_instr_q.delete();
      mpc = RST_PC;
    end else if (bus.i_redirect) begin
      exp_q.delete();
      exp_instr_q.delete();
      mpc = {bus.i_redirect_pc[31:2], 2'b00};
    end else begin
      if (exp_q.size() > 0 && bus.i_id_ready) begin
        void'(exp_q.pop_front());
        void'(exp_instr_q.pop_front());
      end
      if (exp_q.size() < 2) begin
        exp_q.push_back(mpc);
        exp_instr_q.push_back(mem_word(mpc));
        mpc = mpc + 32'd4;
      end
    end
  end

  // Compare process: every falling edge, outputs versus model.
  always @(negedge clk) begin
    check("model_imem_addr", 32'(bus.o_imem_addr), 32'(mpc[AW-1:2]));
    check("model_valid", 32'(bus.o_if_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      check("model_pc", bus.o_if_pc, exp_q[0]);
      check("model_instr", bus.o_if_instr, exp_instr_q[0]);
    end else if (!rstn) begin
      check("model_rst_pc", bus.o_if_pc, 32'h0);
      check("model_rst_instr", bus.o_if_instr, 32'h0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_head(input string name, input logic [31:0] pc, input logic [31:0] instr);
    check({name, "_valid"}, 32'(bus.o_if_valid), 32'h1);
    check({name, "_pc"}, bus.o_if_pc, pc);
    check({name, "_instr"}, bus.o_if_instr, instr);
  endtask

  task automatic expect_bubble(input string name, input logic [31:0] addr);
    check({name, "_valid"}, 32'(bus.o_if_valid), 32'h0);
    check({name, "_addr"}, 32'(bus.o_imem_addr), addr);
  endtask

  task automatic expect_reset_values(input string name);
    check({name, "_valid"}, 32'(bus.o_if_valid), 32'h0);
    check({name, "_addr"}, 32'(bus.o_imem_addr), 32'h0);
    check({name, "_pc"}, bus.o_if_pc, 32'h0);
    check({name, "_instr"}, bus.o_if_instr, 32'h0);
    check({name, "_state"}, 32'(bus.dbg_state), 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = 32'h0;
    bus.i_id_ready    = 1'b0;

    cyc();
    cyc();
    expect_reset_values("reset");

    // 1: stream from RESET_PC
    bus.i_id_ready = 1'b1;
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      expect_head("stream", 32'(4 * i), 32'h1000 + 32'(i));
    end

    // 2: backpressure for 4 cycles; head 0x10 stays, pc freezes at 0x18
    bus.i_id_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      expect_head("stall", 32'h10, 32'h1004);
      check("stall_addr", 32'(bus.o_imem_addr), 32'h6);
      check("stall_state", 32'(bus.dbg_state), 32'h2);
    end
    bus.i_id_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      cyc();
      expect_head("resume", 32'h14 + 32'(4 * j), 32'h1005 + 32'(j));
    end

    // 3: redirect to 0x100 while FULL with decode ready
    check("pre_redir_state", 32'(bus.dbg_state), 32'h2);
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'h100;
    cyc();
    bus.i_redirect = 1'b0;
    expect_bubble("redir", 32'h40);
    cyc();
    expect_head("redir_t0", 32'h100, 32'h1040);
    cyc();
    expect_head("redir_t1", 32'h104, 32'h1041);

    // 4: misaligned redirect target
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'h103;
    cyc();
    bus.i_redirect = 1'b0;
    expect_bubble("misal", 32'h40);
    cyc();
    expect_head("misal_t0", 32'h100, 32'h1040);

    // 5: redirect held 3 cycles with a changing target
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'h200;
    cyc();
    expect_bubble("hold0", 32'h80);
    bus.i_redirect_pc = 32'h300;
    cyc();
    expect_bubble("hold1", 32'hc0);
    bus.i_redirect_pc = 32'h400;
    cyc();
    expect_bubble("hold2", 32'h100);
    bus.i_redirect = 1'b0;
    cyc();
    expect_head("hold_t0", 32'h400, 32'h1100);

    // 6: fill the buffer, then async reset between clock edges
    bus.i_id_ready = 1'b0;
    cyc();
    expect_head("fill", 32'h400, 32'h1100);
    check("fill_state", 32'(bus.dbg_state), 32'h2);
    #2;
    rstn = 1'b0;
    #1;
    expect_reset_values("async_rst");
    cyc();
    expect_reset_values("rst_hold");
    bus.i_id_ready = 1'b1;
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      expect_head("restart", 32'(4 * i), 32'h1000 + 32'(i));
    end

    // Mixed ready pattern, checked by the model every cycle
    for (int i = 0; i < 16; i++) begin
      bus.i_id_ready = (i % 3) != 1;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
